// File: rtl/serial_alu_pkg.sv
// Shared opcodes, FSM states and opcode decode for the
// bit-serial ALU controller.
package serial_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ctrl = {ainv, binv, sel1, sel0}
  typedef struct packed {
    logic [3:0] ctrl;
    logic       cin;
    logic       legal;
  } op_dec_t;

  function automatic op_dec_t op_decode(
    input logic [2:0] op
  );
    op_dec_t d;
    d = '{ctrl: 4'b0000, cin: 1'b0, legal: 1'b0};
    unique case (op)
      OP_ADD:  d = '{4'b0010, 1'b0, 1'b1};
      OP_SUB:  d = '{4'b0110, 1'b1, 1'b1};
      OP_AND:  d = '{4'b0000, 1'b0, 1'b1};
      OP_OR:   d = '{4'b0001, 1'b0, 1'b1};
      OP_NOR:  d = '{4'b1100, 1'b0, 1'b1};
      OP_SLTU: d = '{4'b0111, 1'b1, 1'b1};
      default: d = '{4'b0000, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle between a requester and
// the serial ALU controller.
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero, err
  );
endinterface

// File: rtl/serial_alu_ctrl_alu.sv
// Combinational 1-bit ALU slice: AND, OR, ADD and
// pass-through of the less input, with optional inversion.
module alu (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       ainvert_i,
  input  logic       binvert_i,
  input  logic [1:0] op_i,
  input  logic       cin_i,
  input  logic       less_i,
  output logic       result_o,
  output logic       cout_o
);
  logic ai;
  logic bi;
  logic sum;

  assign ai  = a_i ^ ainvert_i;
  assign bi  = b_i ^ binvert_i;
  assign sum = ai ^ bi ^ cin_i;
  assign cout_o = (ai & bi) | (ai & cin_i) |
                  (bi & cin_i);

  always_comb begin
    result_o = 1'b0;
    unique case (op_i)
      2'b00: result_o = ai & bi;
      2'b01: result_o = ai | bi;
      2'b10: result_o = sum;
      2'b11: result_o = less_i;
      default: result_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Sequences the 1-bit alu slice over WIDTH cycles, LSB
// first, with start/busy/done handshake.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_alu_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  op_dec_t          dec;
  logic             s_res;
  logic             s_cout;
  logic             last;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] final_res;

  assign dec = op_decode(bus.op);

  alu u_alu (
    .a_i       (a_sh_q[0]),
    .b_i       (b_sh_q[0]),
    .ainvert_i (ctrl_q[3]),
    .binvert_i (ctrl_q[2]),
    .op_i      (ctrl_q[1:0]),
    .cin_i     (carry_q),
    .less_i    (1'b0),
    .result_o  (s_res),
    .cout_o    (s_cout)
  );

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign r_next = {s_res, r_sh_q[WIDTH-1:1]};

  // SLTU: no borrow out of a-b means a >= b
  assign final_res = (ctrl_q[1:0] == 2'b11)
    ? {{(WIDTH-1){1'b0}}, ~s_cout}
    : r_next;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          r_sh_d  = '0;
          cnt_d   = '0;
          ctrl_d  = dec.ctrl;
          carry_d = dec.cin;
          err_d   = 1'b0;
          state_d = S_RUN;
          if (!dec.legal) begin
            state_d = S_DONE;
            res_d   = '0;
            cout_d  = 1'b0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = r_next;
        carry_d = s_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          res_d   = final_res;
          cout_d  = ctrl_q[1] & s_cout;
          zero_d  = ~|final_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;
  assign bus.err    = err_q;
endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial N-bit ALU controller. It sequences the existing single-bit `alu` slice (ainvert/binvert/op control, carry in/out) over WIDTH clock cycles, LSB first, to compute word-wide ADD, SUB, AND, OR, NOR and unsigned set-less-than. The block sits between a requester that issues one operation at a time and the one shared 1-bit slice. It owns operand shifting, the carry flip-flop, slice control encoding and the start/busy/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when not busy
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOR, 101 SLTU, 110/111 illegal
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when result becomes valid
- result  out  WIDTH  result, held until next accepted start
- cout  out  1  final carry (ADD/SUB/SLTU), 0 for logic ops
- zero  out  1  result == 0, valid with result
- err  out  1  set with done when op was illegal

## Operation
- Slice control {ainv, binv, sel1, sel0} and initial carry per op: ADD 0010/0, SUB 0110/1, AND 0000/0, OR 0001/0, NOR 1100/0, SLTU 0111/1.
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures a, b and op into shift registers and loads the carry FF with the initial carry. Bit counter is cleared. Next state is RUN; for an illegal op, next state is DONE.
- RUN: each cycle feeds a_sh[0] and b_sh[0] to the slice. Slice result is shifted into result_sh from the MSB side; slice cout goes to the carry FF. Operands shift right. The counter increments, and after the cycle with counter == WIDTH-1 the state moves to DONE.
- SLTU: all WIDTH subtract bits run. result = {WIDTH-1 zeros, ~final carry}, i.e. the slice slt output on the last bit.
- DONE: done=1 for exactly one cycle. result, cout, zero and err are updated from the shift register and carry FF. Next state is IDLE; if start=1 in DONE, a new operation is accepted and the next state is RUN (back-to-back).
- Illegal op: result=0, cout=0, zero=1, err=1. The slice is not sequenced.
- start while busy: ignored, with no effect on operands or state.
- err is cleared on the next accepted start.
- Reset, at any time including mid-RUN: state IDLE; busy, done, cout and err = 0; result = 0; zero = 1; counter, carry FF and shift registers = 0. The in-flight operation is discarded with no done.

## Timing
- Start accepted at edge 0 → busy high for cycles 1..WIDTH → done high in cycle WIDTH+1; result valid from that cycle onward.
- Illegal op: done in cycle 1.
- Throughput: one operation per WIDTH+1 cycles when start is held high.
- All outputs are registered. The slice is purely combinational inside RUN.
- Counter width is $clog2(WIDTH); wrap-around is never reached because the state exits at WIDTH-1.

## Structure
- Package serial_alu_pkg: opcode localparams (OP_ADD … OP_SLTU), the state encoding, and a function mapping opcode → {ctrl[3:0], cin_init, legal}.
- One sub-module instance: the existing `alu` 1-bit slice. Control, carry and shift logic stay in serial_alu_ctrl.

## Test plan
- ADD a=8'hFF, b=8'h01 → done in cycle 9, result=8'h00, cout=1, zero=1, err=0.
- SUB a=8'd5, b=8'd7 → result=8'hFE, cout=0, zero=0. Then NOR a=8'h0F, b=8'h33 → result=8'hC0.
- SLTU a=8'd3, b=8'd200 → result=8'h01. Then SLTU a=8'd200, b=8'd3 → result=8'h00. Then SLTU with a==b → 8'h00.
- ADD 8'h12+8'h34 with start pulsed again at cycle 4 using different operands → second start ignored; result=8'h46. Start held high in DONE → next op begins, with done pulses exactly 9 cycles apart.
- Reset asserted mid-RUN at cycle 4 → all outputs go to reset values immediately (async), no done. A subsequent AND 8'hF0 & 8'h3C → 8'h30.
- op=3'b110 → done in cycle 1, err=1, result=0, zero=1. The next legal start clears err.
